alu_nbit_seq: RTL

WIDTH-bit registered ALU for the MIPS datapath. It generalises the 1-bit slice chain to a parametrised word and keeps the 3-bit op encoding. It adds a start/done handshake, carry/overflow/zero flags, and a multi-cycle unsigned shift-add multiply that writes HI/LO. It sits between the register-file read stage and the writeback mux.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_comb_nbit.sv | 49 ++++
 rtl/alu_nbit_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential N-bit ALU: operation codes and FSM states.
// Optional feature macro used by the ALU: ALU_SEQ_MULT_EN (multi-cycle multiply).
package alu_pkg;

   // 3-bit operation encoding inherited from the 1-bit slice chain
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_MULT = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   // Control FSM: idle/single-cycle work, or iterating a multiply
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_comb_nbit.sv
// Purely combinational WIDTH-bit ALU core for the single-cycle operations
// (and/or/add/sub/slt). Unknown codes give a zero result with cleared flags.
module alu_comb_nbit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_o,
   output logic             cout_o,
   output logic             ovf_o
);

   logic             isSub;
   logic [WIDTH-1:0] bOp;
   logic [WIDTH:0]   sum;
   logic             carryIntoMsb;
   logic             carryOut;
   logic             ovfRaw;

   // sub and slt share one adder in a + ~b + 1 form
   assign isSub        = (op_i == OP_SUB) || (op_i == OP_SLT);
   assign bOp          = isSub ? ~b_i : b_i;
   assign sum          = {1'b0, a_i} + {1'b0, bOp} + {{WIDTH{1'b0}}, isSub};
   assign carryOut     = sum[WIDTH];
   assign carryIntoMsb = a_i[WIDTH-1] ^ bOp[WIDTH-1] ^ sum[WIDTH-1];
   assign ovfRaw       = carryIntoMsb ^ carryOut;

   // Select the raw result and flags for the requested operation
   always_comb begin
      res_o  = '0;
      cout_o = 1'b0;
      ovf_o  = 1'b0;
      case (op_i)
         OP_AND: res_o = a_i & b_i;
         OP_OR:  res_o = a_i | b_i;
         OP_ADD, OP_SUB: begin
            res_o  = sum[WIDTH-1:0];
            cout_o = carryOut;
            ovf_o  = ovfRaw;
         end
         OP_SLT: res_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovfRaw};
         default: res_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU with start/done handshake and carry/overflow/zero flags.
// Define ALU_SEQ_MULT_EN to build the multi-cycle unsigned shift-add multiply
// (op 100, writes HI/LO); without it op 100 behaves like a reserved code.
module alu_nbit_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             cout,
   output logic             zero,
   output logic             ovf
);

   logic [WIDTH-1:0] combRes;
   logic             combCout;
   logic             combOvf;

   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] hi_q;
   logic             cout_q;
   logic             zero_q;
   logic             ovf_q;

   alu_comb_nbit #(.WIDTH(WIDTH)) uComb (
      .op_i   (op),
      .a_i    (a),
      .b_i    (b),
      .res_o  (combRes),
      .cout_o (combCout),
      .ovf_o  (combOvf)
   );

`ifdef ALU_SEQ_MULT_EN
   state_t             state_q;
   logic               busy_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [2*WIDTH-1:0] prod_d;
   logic [WIDTH:0]     upperSum;
   logic               lastStep;

   // One radix-2 step: add the multiplicand into the upper half when the
   // current multiplier LSB is set, then shift the whole product right.
   assign upperSum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign prod_d   = {upperSum, prod_q[WIDTH-1:1]};
   assign cnt_d    = cnt_q + CNT_W'(1);
   assign lastStep = (cnt_d == CNT_W'(WIDTH));

   // FSM plus output registers; reset discards any multiply in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         hi_q     <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (op == OP_MULT) begin
                     mcand_q <= a;
                     prod_q  <= {{WIDTH{1'b0}}, b};
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= ST_MUL;
                  end else begin
                     result_q <= combRes;
                     cout_q   <= combCout;
                     ovf_q    <= combOvf;
                     zero_q   <= (combRes == '0);
                     done_q   <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_d;
               if (lastStep) begin
                  hi_q     <= prod_d[2*WIDTH-1:WIDTH];
                  result_q <= prod_d[WIDTH-1:0];
                  cout_q   <= 1'b0;
                  ovf_q    <= 1'b0;
                  zero_q   <= (prod_d == '0);
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
`else
   // Keeps the counter-width parameter referenced in the multiply-free build
   logic [CNT_W-1:0] unusedCntWidth;
   assign unusedCntWidth = '0;

   // Single-cycle only: register the combinational result on an accepted start
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q   <= 1'b0;
         result_q <= '0;
         hi_q     <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            result_q <= combRes;
            cout_q   <= combCout;
            ovf_q    <= combOvf;
            zero_q   <= (combRes == '0);
            done_q   <= 1'b1;
         end
      end
   end

   assign busy = 1'b0;
`endif

   assign done   = done_q;
   assign result = result_q;
   assign hi     = hi_q;
   assign cout   = cout_q;
   assign zero   = zero_q;
   assign ovf    = ovf_q;

endmodule
